// File: rtl/tristate_bus_responder_pkg.sv
// Shared types and constants for the tristate bus responder.
// State encoding, default geometry and turnaround length.
package tristate_bus_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_DEPTH   = 4;
  localparam int TURN_CYCLES = 1;

  typedef enum logic [2:0] {
    IDLE,
    WR_ACK,
    TURN,
    DRIVE,
    RELEASE
  } state_t;

endpackage

// File: rtl/tristate_bus_responder_if.sv
// Handshake bundle between bus initiator and responder.
// Data travels separately on the shared tristate wire.
interface tristate_bus_responder_if #(
  parameter int DEPTH = tristate_bus_pkg::DEF_DEPTH
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              bus_req;
  logic              bus_wr;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_ack;
  logic              drive_en;
  logic              busy;

  modport master (
    output bus_req, bus_wr, bus_addr,
    input  bus_ack, drive_en, busy
  );

  modport slave (
    input  bus_req, bus_wr, bus_addr,
    output bus_ack, drive_en, busy
  );
endinterface

// File: rtl/tristate_bus_responder_tbuf.sv
// WIDTH-wide tristate driver: passes i_in when enabled,
// otherwise releases the wire to high impedance.
module tristatebuffer #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_in,
  input  logic             i_en,
  output wire  [WIDTH-1:0] o_out
);
  assign o_out = i_en ? i_in : {WIDTH{1'bz}};
endmodule

// File: rtl/tristate_bus_responder.sv
// Responder end of a half-duplex tristate bus: small register
// file, write ack next cycle, read data after one turnaround.
import tristate_bus_pkg::*;

module tristate_bus_responder #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  tristate_bus_responder_if.slave bus,
  inout  wire  [WIDTH-1:0]       bus_data,
  output logic [WIDTH*DEPTH-1:0] regs_flat
);
  localparam int ADDR_W = $clog2(DEPTH);

  state_t           r_state;
  logic             r_ack;
  logic             r_drive_en;
  logic             r_busy;
  logic [1:0]       r_turn;
  logic [WIDTH-1:0] r_rd_q;
  logic [WIDTH-1:0] r_regs [DEPTH];

  logic [ADDR_W-1:0] w_addr;
  assign w_addr = bus.bus_addr;

  // FSM, register file and registered outputs in one process;
  // reset drops drive_en asynchronously even mid-DRIVE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ack      <= 1'b0;
      r_drive_en <= 1'b0;
      r_busy     <= 1'b0;
      r_turn     <= '0;
      r_rd_q     <= '0;
      for (int i = 0; i < DEPTH; i++)
        r_regs[i] <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_ack      <= 1'b0;
          r_drive_en <= 1'b0;
          if (bus.bus_req) begin
            r_busy <= 1'b1;
            if (bus.bus_wr) begin
              r_regs[w_addr] <= bus_data;
              r_ack          <= 1'b1;
              r_state        <= WR_ACK;
            end else begin
              r_rd_q  <= r_regs[w_addr];
              r_turn  <= '0;
              r_state <= TURN;
            end
          end
        end
        WR_ACK: begin
          r_ack   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        TURN: begin
          if (r_turn == 2'(TURN_CYCLES - 1)) begin
            r_drive_en <= 1'b1;
            r_ack      <= 1'b1;
            r_state    <= DRIVE;
          end else begin
            r_turn <= r_turn + 2'd1;
          end
        end
        DRIVE: begin
          r_drive_en <= 1'b0;
          r_ack      <= 1'b0;
          r_state    <= RELEASE;
        end
        RELEASE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.bus_ack  = r_ack;
  assign bus.drive_en = r_drive_en;
  assign bus.busy     = r_busy;

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign regs_flat[g*WIDTH +: WIDTH] = r_regs[g];
  end

  tristatebuffer #(.WIDTH(WIDTH)) u_tbuf (
    .i_in  (r_rd_q),
    .i_en  (r_drive_en),
    .o_out (bus_data)
  );
endmodule

// File: tb/tb_tristate_bus_responder.sv
// Self-checking bench: directed table, corner sequences and
// random traffic against an array-based register model.
module tb_tristate_bus_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tristate_bus_responder_if #(.DEPTH(4)) bif ();

  logic        m_en = 1'b0;
  logic [7:0]  m_data = '0;
  wire  [7:0]  bus_data;
  logic [31:0] regs_flat;

  assign bus_data = m_en ? m_data : 8'bz;

  tristate_bus_responder #(.WIDTH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bif.slave),
    .bus_data  (bus_data),
    .regs_flat (regs_flat)
  );

  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;
  logic [7:0] mregs [4];

  typedef struct {
    bit         wr;
    logic [1:0] addr;
    logic [7:0] data;
  } vec_t;
  vec_t vt [8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Contention / ack monitor sampled away from the active edge.
  always @(negedge clk) begin
    if (bif.bus_ack) ack_cnt++;
    if (m_en && bif.drive_en) begin
      checks++;
      errors++;
      $display("FAIL contention act=both exp=one t=%0t", $time);
    end
    if (bif.drive_en && !m_en && $isunknown(bus_data)) begin
      checks++;
      errors++;
      $display("FAIL bus_x act=%h exp=known", bus_data);
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] model_flat();
    return {mregs[3], mregs[2], mregs[1], mregs[0]};
  endfunction

  task automatic do_wr(input logic [1:0] a, input logic [7:0] d);
    bif.bus_req = 1'b1; bif.bus_wr = 1'b1; bif.bus_addr = a;
    m_en = 1'b1; m_data = d;
    cyc();
    bif.bus_req = 1'b0; m_en = 1'b0;
    mregs[a] = d;
    chk("wr_ack", bif.bus_ack, 1);
    chk("wr_busy", bif.busy, 1);
    chk("wr_drv", bif.drive_en, 0);
    cyc();
    chk("wr_ack_end", bif.bus_ack, 0);
    chk("wr_idle", bif.busy, 0);
  endtask

  task automatic do_rd(input logic [1:0] a);
    logic [7:0] exp;
    exp = mregs[a];
    bif.bus_req = 1'b1; bif.bus_wr = 1'b0; bif.bus_addr = a;
    cyc();
    bif.bus_req = 1'b0;
    chk("turn_ack", bif.bus_ack, 0);
    chk("turn_drv", bif.drive_en, 0);
    cyc();
    chk("drv_ack", bif.bus_ack, 1);
    chk("drv_en", bif.drive_en, 1);
    chk("rd_data", bus_data, exp);
    cyc();
    chk("rel_drv", bif.drive_en, 0);
    chk("rel_busy", bif.busy, 1);
    cyc();
    chk("rd_idle", bif.busy, 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mregs[i] = '0;
  endtask

  initial begin
    bif.bus_req = 1'b0; bif.bus_wr = 1'b0; bif.bus_addr = '0;
    model_reset();
    vt[0] = '{1'b1, 2'd2, 8'hA5};
    vt[1] = '{1'b0, 2'd2, 8'h00};
    vt[2] = '{1'b1, 2'd0, 8'h5A};
    vt[3] = '{1'b1, 2'd1, 8'hC3};
    vt[4] = '{1'b0, 2'd0, 8'h00};
    vt[5] = '{1'b0, 2'd1, 8'h00};
    vt[6] = '{1'b0, 2'd3, 8'h00};
    vt[7] = '{1'b1, 2'd3, 8'hFF};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    cyc();
    chk("rst_ack", bif.bus_ack, 0);
    chk("rst_drv", bif.drive_en, 0);
    chk("rst_busy", bif.busy, 0);
    chk("rst_regs", regs_flat, 0);

    // Directed table.
    foreach (vt[i]) begin
      if (vt[i].wr) do_wr(vt[i].addr, vt[i].data);
      else do_rd(vt[i].addr);
      chk("tbl_regs", regs_flat, model_flat());
    end
    chk("a5_slot", regs_flat[23:16], 8'hA5);

    // Asynchronous reset with no clock edge.
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("arst_ack", bif.bus_ack, 0);
    chk("arst_drv", bif.drive_en, 0);
    chk("arst_regs", regs_flat, 0);
    @(negedge clk);
    rst = 1'b0;
    cyc();

    // Request while busy: ignored in TURN and in RELEASE.
    ack_cnt = 0;
    bif.bus_req = 1'b1; bif.bus_wr = 1'b0; bif.bus_addr = 2'd0;
    cyc();
    bif.bus_wr = 1'b1; bif.bus_addr = 2'd1;
    m_en = 1'b1; m_data = 8'hFF;
    @(posedge clk);
    #1 m_en = 1'b0; bif.bus_req = 1'b0;
    @(negedge clk);
    chk("busy_rd_data", bus_data, 8'h00);
    cyc();
    bif.bus_req = 1'b1; m_en = 1'b1;
    cyc();
    bif.bus_req = 1'b0; m_en = 1'b0;
    chk("busy_idle", bif.busy, 0);
    cyc();
    chk("busy_reg1", regs_flat[15:8], 8'h00);
    chk("busy_acks", ack_cnt, 1);

    // Reset during DRIVE.
    bif.bus_req = 1'b1; bif.bus_wr = 1'b0; bif.bus_addr = 2'd2;
    cyc();
    bif.bus_req = 1'b0;
    cyc();
    chk("pre_rst_drv", bif.drive_en, 1);
    #2 rst = 1'b1;
    #1;
    chk("drv_rst_en", bif.drive_en, 0);
    chk("drv_rst_busy", bif.busy, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    do_wr(2'd3, 8'h3C);
    chk("post_rst_regs", regs_flat, 32'h3C00_0000);

    // Back-to-back writes then read-after-write.
    ack_cnt = 0;
    do_wr(2'd0, 8'h11);
    do_wr(2'd1, 8'h22);
    do_wr(2'd2, 8'h33);
    do_wr(2'd3, 8'h44);
    chk("b2b_acks", ack_cnt, 4);
    chk("b2b_regs", regs_flat, 32'h4433_2211);
    do_wr(2'd1, 8'h9E);
    do_rd(2'd1);

    // Random traffic against the model.
    for (int n = 0; n < 80; n++) begin
      logic [1:0] a;
      logic [7:0] d;
      a = 2'($urandom_range(0, 3));
      d = 8'($urandom);
      if ($urandom_range(0, 1) == 1) do_wr(a, d);
      else do_rd(a);
      chk("rnd_regs", regs_flat, model_flat());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tristate_bus_responder.md
Name: tristate_bus_responder

Overview:
- Responder (target) end of the shared tristate data bus. Bus initiators drive the bus through tristate buffers: `enable ? in : Z`.
- Holds a small register file. Accepts write and read requests on a half-duplex bidirectional data bus.
- For reads, the responder turns the bus around and drives the data back through its own tristate driver.
- Sits on the far side of the shared bus from the initiator's tristate buffer.

Parameters:
- WIDTH, 8, data bus and register width in bits
- DEPTH, 4, number of registers; power of two, at least 2
- ADDR_W, $clog2(DEPTH), localparam derived from DEPTH; not overridable

Ports:
- clk  input  1  single system clock, rising edge
- rst  input  1  asynchronous active-high reset
- bus_req  input  1  initiator request strobe, one cycle per transaction
- bus_wr  input  1  transaction type qualifier, valid with bus_req: 1 = write, 0 = read
- bus_addr  input  ADDR_W  register index, valid with bus_req
- bus_data  inout  WIDTH  shared tristate data bus
- bus_ack  output  1  transaction acknowledge, one-cycle pulse
- drive_en  output  1  responder's tristate enable, exported for bench and monitoring
- busy  output  1  high whenever state is not IDLE
- regs_flat  output  WIDTH*DEPTH  register file contents; reg i occupies bits [i*WIDTH +: WIDTH]

Behaviour:
- Interface (decided): one clock, clk. Reset rst is asynchronous and active-high.
- bus_data is driven only through `drive_en ? rd_q : {WIDTH{1'bz}}`. It is Z at every other time.
- Reset values: state=IDLE, bus_ack=0, drive_en=0, busy=0, all registers 0, rd_q=0.
- On rst assertion, drive_en falls immediately (asynchronous) and bus_data goes Z. This holds even mid-DRIVE.
- FSM states: IDLE, WR_ACK, TURN, DRIVE, RELEASE.
- IDLE:
  - bus_req=1 and bus_wr=1 at edge k: reg[bus_addr] <= bus_data at edge k; go to WR_ACK.
  - bus_req=1 and bus_wr=0 at edge k: rd_q <= reg[bus_addr]; go to TURN.
- WR_ACK: bus_ack=1 for exactly one cycle (k to k+1); go to IDLE. The write acknowledge appears one cycle after the request.
- TURN: bus_ack=0, drive_en=0 for one cycle. This is the mandatory turnaround, so the initiator's driver is released before the responder drives; the bus is Z. Go to DRIVE.
- DRIVE: drive_en=1, bus_ack=1, bus_data=rd_q for exactly one cycle. Read data is valid in the second cycle after the request. Go to RELEASE.
- RELEASE: drive_en=0, bus_ack=0 for one cycle, so there is no overlap with the next initiator drive. Go to IDLE.
- Throughput:
  - Write: one transaction per 2 cycles.
  - Read: one transaction per 4 cycles.
  - A new request is accepted only in IDLE, including the cycle in which IDLE is re-entered.
- bus_req while busy=1 is ignored: no register change, no ack, no queued request. Initiators must wait for busy=0.
- All outputs (bus_ack, drive_en, busy) are registered or decoded from state only. There is no combinational path from bus inputs to outputs.
- drive_en is high in DRIVE only. The FSM never has drive_en=1 in the same cycle that bus_req is sampled.
- Read-after-write: a read to the same address issued in the cycle after WR_ACK returns the new value.
- bus_addr ≥ DEPTH cannot occur because DEPTH is a power of two.
- rd_q is captured at request time. A later write cannot corrupt an in-flight read, and writes are blocked while busy anyway.
- Reset mid-transaction:
  - Abandons the transaction and returns to IDLE.
  - A write already sampled at edge k is retained unless reset clears the registers. Reset always clears all registers to 0.

Decomposition:
- Shared package tristate_bus_pkg holds:
  - the state typedef (IDLE, WR_ACK, TURN, DRIVE, RELEASE)
  - default bus width and depth constants
  - the turnaround-cycle constant (1)
- One natural sub-module: the existing tristatebuffer, instantiated once per bit or as a WIDTH-wide variant, to drive bus_data from rd_q and drive_en. The FSM and register file stay in tristate_bus_responder.

Test Plan:
- Reset:
  - Stimulus: assert rst mid-simulation with no clock edge.
  - Required: bus_ack=0, drive_en=0, bus_data=Z immediately, regs_flat=0.
- Write then read (WIDTH=8):
  - Stimulus: write 0xA5 to addr 2, then after busy=0 issue a read of addr 2.
  - Required: bus_ack pulse at k+1 for the write. For the read, bus_data is Z in TURN, 0xA5 with bus_ack=1 at k+2, then Z.
  - Required: regs_flat[23:16]=0xA5.
- Request while busy:
  - Stimulus: read addr 0, then assert bus_req with a write of 0xFF to addr 1 during TURN.
  - Required: the write is ignored, reg1 stays 0, exactly one ack is seen.
- Contention check:
  - Stimulus: back-to-back reads and writes across all 4 addresses.
  - Required: a bench monitor never sees the initiator enable and drive_en both high. bus_data is never X while exactly one driver is enabled.
- Reset during DRIVE:
  - Stimulus: assert rst in the DRIVE cycle.
  - Required: drive_en drops before the next edge, bus_data=Z. After rst is released, the FSM is in IDLE and the next write of 0x3C to addr 3 is acknowledged normally.
- Back-to-back writes:
  - Stimulus: writes of 0x11, 0x22, 0x33, 0x44 to addrs 0-3, each issued the cycle after WR_ACK.
  - Required: four acks, regs_flat=0x44332211.
